obi_rr_slave_arbiter: RTL and testbench

- Shares one OBI slave port, such as a RAM bank or a peripheral bus, between NMASTER OBI requesters using round-robin arbitration.
- Sits between the system crossbar demux outputs and a single slave in the onetoM/NtoM bus fabric.
- Keeps an in-order master-ID queue so that each R-channel response goes back to the master that issued the request.
- Stalls new grants once MAX_OUTSTANDING requests are in flight.

---
 rtl/obi_rr_slave_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_obi_rr_slave_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/obi_rr_slave_arbiter.sv
// Round-robin arbiter sharing one OBI slave among NMASTER requesters, with an in-order
// master-ID queue for response routing. Optional counters: define OBI_RR_ARB_PERF_CNT_EN.
module obi_rr_slave_arbiter #(
  parameter int NMASTER         = 5,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NMASTER-1:0]                   m_req_i,
  output logic [NMASTER-1:0]                   m_gnt_o,
  input  logic [NMASTER*ADDR_W-1:0]            m_addr_i,
  input  logic [NMASTER-1:0]                   m_we_i,
  input  logic [NMASTER*DATA_W/8-1:0]          m_be_i,
  input  logic [NMASTER*DATA_W-1:0]            m_wdata_i,
  output logic [NMASTER-1:0]                   m_rvalid_o,
  output logic [DATA_W-1:0]                    m_rdata_o,
  output logic                                 s_req_o,
  input  logic                                 s_gnt_i,
  output logic [ADDR_W-1:0]                    s_addr_o,
  output logic                                 s_we_o,
  output logic [DATA_W/8-1:0]                  s_be_o,
  output logic [DATA_W-1:0]                    s_wdata_o,
  input  logic                                 s_rvalid_i,
  input  logic [DATA_W-1:0]                    s_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 err_unexp_rvalid_o
`ifdef OBI_RR_ARB_PERF_CNT_EN
  ,
  input  logic                                 perf_clr_i,
  output logic [NMASTER*32-1:0]                perf_gnt_cnt_o,
  output logic [31:0]                          perf_stall_cnt_o
`endif
);

  localparam int PTR_W = $clog2(NMASTER);
  localparam int QW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int BE_W  = DATA_W / 8;

  logic [PTR_W-1:0] rr_ptr_r;
  logic [PTR_W-1:0] id_q_r [MAX_OUTSTANDING];
  logic [QW-1:0]    head_r;
  logic [QW-1:0]    tail_r;
  logic [CNT_W-1:0] count_r;
  logic             err_r;

  logic [PTR_W-1:0] winner_s;
  logic [PTR_W-1:0] hi_win_s;
  logic [PTR_W-1:0] lo_win_s;
  logic             hi_found_s;
  logic             any_req_s;
  logic             stall_s;
  logic             hs_s;
  logic             pop_s;
  logic             unexp_s;
  logic [PTR_W-1:0] head_id_s;
  logic [PTR_W-1:0] rr_next_s;
  logic [QW-1:0]    head_next_s;
  logic [QW-1:0]    tail_next_s;

  assign any_req_s = |m_req_i;
  assign stall_s   = (count_r == CNT_W'(MAX_OUTSTANDING));
  assign s_req_o   = any_req_s & ~stall_s;
  assign hs_s      = s_req_o & s_gnt_i;
  assign pop_s     = s_rvalid_i & (count_r != {CNT_W{1'b0}});
  assign unexp_s   = s_rvalid_i & (count_r == {CNT_W{1'b0}});
  assign head_id_s = id_q_r[head_r];

  assign rr_next_s   = (winner_s == PTR_W'(NMASTER - 1)) ? {PTR_W{1'b0}} : winner_s + PTR_W'(1);
  assign head_next_s = (head_r == QW'(MAX_OUTSTANDING - 1)) ? {QW{1'b0}} : head_r + QW'(1);
  assign tail_next_s = (tail_r == QW'(MAX_OUTSTANDING - 1)) ? {QW{1'b0}} : tail_r + QW'(1);

  assign m_rdata_o          = s_rdata_i;
  assign outstanding_o      = count_r;
  assign err_unexp_rvalid_o = err_r;

  // Round-robin search: lowest requester at or above rr_ptr, else lowest below it.
  always_comb begin
    hi_win_s   = {PTR_W{1'b0}};
    lo_win_s   = {PTR_W{1'b0}};
    hi_found_s = 1'b0;
    for (int k = NMASTER - 1; k >= 0; k--) begin
      if (m_req_i[k]) begin
        if (PTR_W'(k) >= rr_ptr_r) begin
          hi_win_s   = PTR_W'(k);
          hi_found_s = 1'b1;
        end else begin
          lo_win_s = PTR_W'(k);
        end
      end else begin
        hi_found_s = hi_found_s;
      end
    end
    if (hi_found_s) begin
      winner_s = hi_win_s;
    end else begin
      winner_s = lo_win_s;
    end
  end

  // A-channel mux from the winner; all-zero while no request is presented.
  always_comb begin
    s_addr_o  = {ADDR_W{1'b0}};
    s_we_o    = 1'b0;
    s_be_o    = {BE_W{1'b0}};
    s_wdata_o = {DATA_W{1'b0}};
    for (int k = 0; k < NMASTER; k++) begin
      if (s_req_o && (PTR_W'(k) == winner_s)) begin
        s_addr_o  = m_addr_i[k*ADDR_W +: ADDR_W];
        s_we_o    = m_we_i[k];
        s_be_o    = m_be_i[k*BE_W +: BE_W];
        s_wdata_o = m_wdata_i[k*DATA_W +: DATA_W];
      end else begin
        s_we_o = s_we_o;
      end
    end
  end

  // One-hot grant to the winner and response valid to the queue head.
  always_comb begin
    m_gnt_o    = {NMASTER{1'b0}};
    m_rvalid_o = {NMASTER{1'b0}};
    for (int k = 0; k < NMASTER; k++) begin
      if (hs_s && (PTR_W'(k) == winner_s)) begin
        m_gnt_o[k] = 1'b1;
      end else begin
        m_gnt_o[k] = 1'b0;
      end
      if (pop_s && (PTR_W'(k) == head_id_s)) begin
        m_rvalid_o[k] = 1'b1;
      end else begin
        m_rvalid_o[k] = 1'b0;
      end
    end
  end

  // Arbitration pointer, ID queue and sticky unexpected-response flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_r <= {PTR_W{1'b0}};
      head_r   <= {QW{1'b0}};
      tail_r   <= {QW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      err_r    <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        id_q_r[i] <= {PTR_W{1'b0}};
      end
    end else begin
      if (hs_s) begin
        rr_ptr_r       <= rr_next_s;
        id_q_r[tail_r] <= winner_s;
        tail_r         <= tail_next_s;
      end
      if (pop_s) begin
        head_r <= head_next_s;
      end
      case ({hs_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (unexp_s) begin
        err_r <= 1'b1;
      end
    end
  end

`ifdef OBI_RR_ARB_PERF_CNT_EN
  logic [31:0] perf_gnt_r [NMASTER];
  logic [31:0] perf_stall_r;

  // Saturating per-master handshake and stall-cycle counters; clear wins over increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_stall_r <= 32'd0;
      for (int k = 0; k < NMASTER; k++) begin
        perf_gnt_r[k] <= 32'd0;
      end
    end else if (perf_clr_i) begin
      perf_stall_r <= 32'd0;
      for (int k = 0; k < NMASTER; k++) begin
        perf_gnt_r[k] <= 32'd0;
      end
    end else begin
      if (hs_s && (perf_gnt_r[winner_s] != 32'hFFFF_FFFF)) begin
        perf_gnt_r[winner_s] <= perf_gnt_r[winner_s] + 32'd1;
      end
      if (any_req_s && !hs_s && (perf_stall_r != 32'hFFFF_FFFF)) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
    end
  end

  assign perf_stall_cnt_o = perf_stall_r;
  for (genvar g = 0; g < NMASTER; g++) begin : g_perf
    assign perf_gnt_cnt_o[g*32 +: 32] = perf_gnt_r[g];
  end
`endif

endmodule

// File: tb/tb_obi_rr_slave_arbiter.sv
// Randomised bench for obi_rr_slave_arbiter against a queue-based reference model.
module tb_obi_rr_slave_arbiter;
  localparam int NM = 5;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;
  localparam int BW = DW / 8;
  localparam int CW = $clog2(MO + 1);

  logic clk = 1'b0;
  logic rst;
  logic [NM-1:0]    m_req, m_gnt, m_we, m_rvalid;
  logic [NM*AW-1:0] m_addr;
  logic [NM*BW-1:0] m_be;
  logic [NM*DW-1:0] m_wdata;
  logic [DW-1:0]    m_rdata;
  logic             s_req, s_gnt, s_we, s_rvalid;
  logic [AW-1:0]    s_addr;
  logic [BW-1:0]    s_be;
  logic [DW-1:0]    s_wdata, s_rdata;
  logic [CW-1:0]    outstanding;
  logic             err;
  logic             perf_clr = 1'b0;
`ifdef OBI_RR_ARB_PERF_CNT_EN
  logic [NM*32-1:0] perf_gnt;
  logic [31:0]      perf_stall;
  longint           pg [NM];
  longint           ps;
`endif

  obi_rr_slave_arbiter #(.NMASTER(NM), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req), .m_gnt_o(m_gnt), .m_addr_i(m_addr), .m_we_i(m_we), .m_be_i(m_be),
    .m_wdata_i(m_wdata), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
    .s_req_o(s_req), .s_gnt_i(s_gnt), .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be),
    .s_wdata_o(s_wdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .outstanding_o(outstanding), .err_unexp_rvalid_o(err)
`ifdef OBI_RR_ARB_PERF_CNT_EN
    , .perf_clr_i(perf_clr), .perf_gnt_cnt_o(perf_gnt), .perf_stall_cnt_o(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: round-robin pointer, in-flight IDs with their expected read data.
  int            rr;
  int            idq[$];
  logic [DW-1:0] dq[$];
  bit            err_m;
  logic [DW-1:0] sq[$];
  bit            act [NM];
  logic [AW-1:0] a_addr [NM];
  logic          a_we [NM];
  logic [BW-1:0] a_be [NM];
  logic [DW-1:0] a_wdata [NM];
  int            clr_pct = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] resp(input logic [AW-1:0] a);
    return DW'(a ^ 32'hA5A5_0F0F) + DW'(32'd17);
  endfunction

  task automatic model_clear();
    rr = 0;
    idq.delete();
    dq.delete();
    sq.delete();
    err_m = 1'b0;
    for (int k = 0; k < NM; k++) act[k] = 1'b0;
`ifdef OBI_RR_ARB_PERF_CNT_EN
    for (int k = 0; k < NM; k++) pg[k] = 0;
    ps = 0;
`endif
  endtask

  task automatic do_reset();
    m_req = '0; m_addr = '0; m_we = '0; m_be = '0; m_wdata = '0;
    s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0; perf_clr = 1'b0;
    #1 rst = 1'b1;
    model_clear();
    @(posedge clk); #2;
    chk("rst_gnt", 64'(m_gnt), 64'd0);
    chk("rst_sreq", 64'(s_req), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rvalid", 64'(m_rvalid), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic run(input int n, input logic [NM-1:0] mask, input int req_pct,
                     input int gnt_pct, input int rv_pct, input bit inject);
    for (int c = 0; c < n; c++) begin
      int w;
      bit stall, esreq, ehs, epop;
      logic [NM-1:0] egnt, erv;
      @(posedge clk); #1;
      for (int k = 0; k < NM; k++) begin
        if (!act[k] && mask[k] && ($urandom % 100 < req_pct)) begin
          act[k] = 1'b1; a_addr[k] = $urandom; a_we[k] = 1'($urandom);
          a_be[k] = BW'($urandom); a_wdata[k] = $urandom;
        end
        m_req[k] = act[k];
        m_addr[k*AW +: AW] = act[k] ? a_addr[k] : AW'($urandom);
        m_we[k] = act[k] ? a_we[k] : 1'b0;
        m_be[k*BW +: BW] = act[k] ? a_be[k] : '0;
        m_wdata[k*DW +: DW] = act[k] ? a_wdata[k] : DW'($urandom);
      end
      s_gnt = ($urandom % 100 < gnt_pct);
      if (sq.size() > 0) begin
        s_rvalid = ($urandom % 100 < rv_pct);
        s_rdata  = sq[0];
      end else begin
        s_rvalid = inject;
        s_rdata  = $urandom;
      end
      perf_clr = ($urandom % 100 < clr_pct);
      #1;
      stall = (idq.size() == MO);
      w = -1;
      for (int i = 0; i < NM; i++) if (w < 0 && m_req[(rr + i) % NM]) w = (rr + i) % NM;
      esreq = (w >= 0) && !stall;
      ehs   = esreq && s_gnt;
      egnt  = '0;
      if (ehs) egnt[w] = 1'b1;
      chk("s_req", 64'(s_req), 64'(esreq));
      chk("m_gnt", 64'(m_gnt), 64'(egnt));
      chk("s_addr", 64'(s_addr), esreq ? 64'(a_addr[w]) : 64'd0);
      chk("s_we", 64'(s_we), esreq ? 64'(a_we[w]) : 64'd0);
      chk("s_be", 64'(s_be), esreq ? 64'(a_be[w]) : 64'd0);
      chk("s_wdata", 64'(s_wdata), esreq ? 64'(a_wdata[w]) : 64'd0);
      chk("outstanding", 64'(outstanding), 64'(idq.size()));
      chk("err", 64'(err), 64'(err_m));
      epop = s_rvalid && (idq.size() > 0);
      erv  = '0;
      if (epop) begin
        erv[idq[0]] = 1'b1;
        chk("m_rdata", 64'(m_rdata), 64'(dq[0]));
      end
      chk("m_rvalid", 64'(m_rvalid), 64'(erv));
`ifdef OBI_RR_ARB_PERF_CNT_EN
      for (int k = 0; k < NM; k++) chk("perf_gnt", 64'(perf_gnt[k*32 +: 32]), 64'(pg[k]));
      chk("perf_stall", 64'(perf_stall), 64'(ps));
      if (perf_clr) begin
        for (int k = 0; k < NM; k++) pg[k] = 0;
        ps = 0;
      end else begin
        if (ehs) pg[w]++;
        if ((w >= 0) && !ehs) ps++;
      end
`endif
      if (s_rvalid && idq.size() == 0) err_m = 1'b1;
      if (epop) begin
        void'(idq.pop_front());
        void'(dq.pop_front());
      end
      if (ehs) begin
        idq.push_back(w);
        dq.push_back(resp(a_addr[w]));
        rr = (w + 1) % NM;
      end
      if (s_rvalid && sq.size() > 0) void'(sq.pop_front());
      if (s_req && s_gnt) sq.push_back(resp(s_addr));
      for (int k = 0; k < NM; k++) if (m_gnt[k]) act[k] = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    do_reset();
    run(12, 5'h1F, 100, 100, 100, 1'b0);   // all masters streaming, zero-latency slave
    do_reset();
    run(8, 5'b01000, 100, 100, 100, 1'b0); // master 3 alone, back-to-back
    do_reset();
    run(5, 5'h1F, 100, 100, 0, 1'b0);      // responses withheld: fills to the limit
    run(1, 5'h1F, 100, 100, 100, 1'b0);
    run(2, 5'h1F, 100, 100, 0, 1'b0);
    run(6, 5'h00, 0, 0, 100, 1'b0);
    run(1, 5'h00, 0, 0, 0, 1'b1);          // response with nothing in flight
    run(3, 5'h00, 0, 0, 0, 1'b0);
    do_reset();
    run(3, 5'b10010, 100, 0, 100, 1'b0);   // masters 1 and 4 held off by the slave
    run(3, 5'b10010, 100, 100, 100, 1'b0);
    do_reset();
    run(10, 5'b00100, 100, 100, 100, 1'b0);
    run(4, 5'b00100, 100, 0, 100, 1'b0);
    clr_pct = 100;
    run(1, 5'h00, 0, 0, 100, 1'b0);
    clr_pct = 0;
    run(2, 5'h00, 0, 0, 100, 1'b0);
    clr_pct = 2;
    for (int r = 0; r < 40; r++) begin
      run($urandom_range(20, 80), NM'($urandom), $urandom_range(10, 100),
          $urandom_range(0, 100), $urandom_range(0, 100), ($urandom % 8 == 0));
      if ($urandom % 6 == 0) do_reset();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
